data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mips_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/data_mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, port
// indices and the burst counter width.
package mips_pkg;

    localparam int unsigned BURST_CNT_W = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    // Owner state that corresponds to a granted port index
    function automatic owner_e owner_of(input logic port);
        return (port == PORT1) ? OWN_P1 : OWN_P0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-request round-robin picker: on contention the port that did not win
// last time is chosen; a lone requester always wins.
module rr_pick2
    import mips_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0_c,
    output logic gnt1_c
);

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0 && req1) begin
            gnt0_c = (last_gnt == PORT1);
            gnt1_c = (last_gnt == PORT0);
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port data memory between the CPU (port 0) and a
// debug/DMA master (port 1), with bounded locked bursts and registered reads.
module data_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wd0,
    input  logic [DATA_WIDTH-1:0] wd1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  stall0,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [BURST_CNT_W-1:0] CNT_LIM = BURST_CNT_W'(MAX_BURST - 1);

    owner_e                 owner, owner_nxt;
    logic                   last_gnt, last_gnt_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;

    logic hold0, hold1, held;
    logic rr0, rr1;

    assign hold0 = (owner == OWN_P0) && req0 && lock0 && (burst_cnt < CNT_LIM);
    assign hold1 = (owner == OWN_P1) && req1 && lock1 && (burst_cnt < CNT_LIM);

    rr_pick2 u_rr (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt0_c   (rr0),
        .gnt1_c   (rr1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= OWN_NONE;
            last_gnt  <= PORT1;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            last_gnt  <= last_gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant selection and next-state; grants are forced low while in reset
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        held          = 1'b0;
        owner_nxt     = OWN_NONE;
        last_gnt_nxt  = last_gnt;
        burst_cnt_nxt = '0;

        if (reset) begin
            if (hold0) begin
                gnt0 = 1'b1;
                held = 1'b1;
            end else if (hold1) begin
                gnt1 = 1'b1;
                held = 1'b1;
            end else begin
                gnt0 = rr0;
                gnt1 = rr1;
            end
        end

        if (gnt0 || gnt1) begin
            last_gnt_nxt = gnt1 ? PORT1 : PORT0;
            if ((gnt0 && lock0) || (gnt1 && lock1)) begin
                owner_nxt     = owner_of(gnt1 ? PORT1 : PORT0);
                burst_cnt_nxt = held ? BURST_CNT_W'(burst_cnt + 1'b1) : '0;
            end
        end
    end

    assign stall0   = req0 & ~gnt0;
    assign mem_we   = (gnt0 & we0) | (gnt1 & we1);
    assign mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
    assign mem_wd   = gnt0 ? wd0   : (gnt1 ? wd1   : '0);

    // Read response: one-cycle pulse per read beat, data held between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_rd;
            if (gnt1 && !we1) rdata1 <= mem_rd;
        end
    end

endmodule
